writeback_arbiter: RTL and testbench

Write-back stage directly upstream of the register file's single write port. Merges single-cycle ALU results with decoupled load-unit results, buffered in a small FIFO. Drives a registered `write_address`/`write_data`/`write_enable` triple straight into the register file. Also exports a pending-destination mask so decode can stall on load-use hazards.

---
 rtl/writeback_arbiter.sv | 144 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//
// Write-back stage feeding the register file's single write port. Single-cycle
// ALU results always win the port; load results are buffered in a small
// circular FIFO and drained whenever no ALU write occupies the cycle. The
// ALU result is the newer write, so an ALU write kills any queued load to the
// same destination.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data  ALU result, no backpressure
//   mem_valid/mem_rd/mem_data  load result offer; accepted when mem_ready
//   mem_ready                FIFO can accept (low in reset and when full)
//   write_address/_data/_enable  registered write-port triple
//   pending_mask             destinations queued (live) or staged; bit 0 is 0

module writeback_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic [4:0]  write_address,
    output logic [31:0] write_data,
    output logic        write_enable,
    output logic [31:0] pending_mask
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [4:0]       fifo_rd_q   [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic [4:0]  write_address_q, write_address_d;
    logic [31:0] write_data_q,    write_data_d;
    logic        write_enable_q,  write_enable_d;

    logic full, empty, alu_eff, push, pop, push_live;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign mem_ready = !rst && !full;
    assign alu_eff   = alu_valid && (alu_rd != 5'd0);
    assign push      = mem_valid && mem_ready;
    // Pop decision uses pre-edge occupancy, so a load pushed into an empty
    // FIFO cannot be popped on the same edge.
    assign pop       = !alu_eff && !empty;
    // A load to x0, or one overtaken by a same-cycle ALU write, is queued dead.
    assign push_live = (mem_rd != 5'd0) && !(alu_eff && (alu_rd == mem_rd));

    always_comb begin
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        write_enable_d  = 1'b0;
        count_d         = count_q;
        if (alu_eff) begin
            write_address_d = alu_rd;
            write_data_d    = alu_data;
            write_enable_d  = 1'b1;
        end else if (pop) begin
            // Dead entries still load address/data but do not enable the write.
            write_address_d = fifo_rd_q[rd_ptr_q];
            write_data_d    = fifo_data_q[rd_ptr_q];
            write_enable_d  = live_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state and the staged write: cleared by reset so nothing partial
    // is ever emitted after a mid-operation reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q          <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            write_address_q <= '0;
            write_data_q    <= '0;
            write_enable_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_eff && (fifo_rd_q[i] == alu_rd)) begin
                    live_q[i] <= 1'b0;
                end
            end
            // Clearing live on pop keeps pending_mask a plain OR over live bits.
            if (pop) begin
                live_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                live_q[wr_ptr_q] <= push_live;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            count_q         <= count_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            write_enable_q  <= write_enable_d;
        end
    end

    // Payload storage needs no reset: an entry is only observed while live
    // or once popped after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= mem_rd;
            fifo_data_q[wr_ptr_q] <= mem_data;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pending_mask[fifo_rd_q[i]] = 1'b1;
            end
        end
        if (write_enable_q) begin
            pending_mask[write_address_q] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign write_enable  = write_enable_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] pending_mask;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .pending_mask  (pending_mask)
    );

    // Register file downstream of the write port.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (write_enable) rf[write_address] <= write_data;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        erdy;
        logic [31:0] emask;
    } vec_t;

    localparam int NV = 31;
    vec_t vt [NV];

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                                input logic erdy, input logic [31:0] emask);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
        v.ewe = ewe; v.ea = ea; v.ed = ed; v.erdy = erdy; v.emask = emask;
        return v;
    endfunction

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = '0;

        // Each row: inputs before an edge, outputs expected 1ns after it.
        //          alu           mem                 expected we/addr/data/ready/mask
        vt[0]  = mk(1, 5, 32'hcafebabe, 0, 0, 0,      1, 5, 32'hcafebabe, 1, 32'h20);
        vt[1]  = mk(1, 0, 32'h00001234, 0, 0, 0,      0, 5, 32'hcafebabe, 1, 32'h0);
        vt[2]  = mk(0, 0, 0, 1, 1, 32'h11,            0, 5, 32'hcafebabe, 1, 32'h2);
        vt[3]  = mk(0, 0, 0, 1, 2, 32'h22,            1, 1, 32'h11, 1, 32'h6);
        vt[4]  = mk(0, 0, 0, 1, 3, 32'h33,            1, 2, 32'h22, 1, 32'hC);
        vt[5]  = mk(0, 0, 0, 1, 4, 32'h44,            1, 3, 32'h33, 1, 32'h18);
        vt[6]  = mk(0, 0, 0, 0, 0, 0,                 1, 4, 32'h44, 1, 32'h10);
        vt[7]  = mk(0, 0, 0, 0, 0, 0,                 0, 4, 32'h44, 1, 32'h0);
        vt[8]  = mk(1, 7, 32'h70, 1, 1, 32'h11,       1, 7, 32'h70, 1, 32'h82);
        vt[9]  = mk(1, 7, 32'h71, 1, 2, 32'h22,       1, 7, 32'h71, 1, 32'h86);
        vt[10] = mk(1, 7, 32'h72, 1, 3, 32'h33,       1, 7, 32'h72, 1, 32'h8E);
        vt[11] = mk(1, 7, 32'h73, 1, 4, 32'h44,       1, 7, 32'h73, 0, 32'h9E);
        vt[12] = mk(0, 0, 0, 1, 5, 32'h55,            1, 1, 32'h11, 1, 32'h1E);
        vt[13] = mk(0, 0, 0, 0, 0, 0,                 1, 2, 32'h22, 1, 32'h1C);
        vt[14] = mk(0, 0, 0, 0, 0, 0,                 1, 3, 32'h33, 1, 32'h18);
        vt[15] = mk(0, 0, 0, 0, 0, 0,                 1, 4, 32'h44, 1, 32'h10);
        vt[16] = mk(0, 0, 0, 0, 0, 0,                 0, 4, 32'h44, 1, 32'h0);
        vt[17] = mk(0, 0, 0, 1, 3, 32'hdeadbeef,      0, 4, 32'h44, 1, 32'h8);
        vt[18] = mk(1, 8, 32'h80, 0, 0, 0,            1, 8, 32'h80, 1, 32'h108);
        vt[19] = mk(1, 8, 32'h81, 0, 0, 0,            1, 8, 32'h81, 1, 32'h108);
        vt[20] = mk(1, 8, 32'h82, 0, 0, 0,            1, 8, 32'h82, 1, 32'h108);
        vt[21] = mk(0, 0, 0, 0, 0, 0,                 1, 3, 32'hdeadbeef, 1, 32'h8);
        vt[22] = mk(0, 0, 0, 0, 0, 0,                 0, 3, 32'hdeadbeef, 1, 32'h0);
        vt[23] = mk(0, 0, 0, 1, 6, 32'h1,             0, 3, 32'hdeadbeef, 1, 32'h40);
        vt[24] = mk(1, 6, 32'h2, 0, 0, 0,             1, 6, 32'h2, 1, 32'h40);
        vt[25] = mk(0, 0, 0, 0, 0, 0,                 0, 6, 32'h1, 1, 32'h0);
        vt[26] = mk(0, 0, 0, 0, 0, 0,                 0, 6, 32'h1, 1, 32'h0);
        vt[27] = mk(1, 9, 32'h99, 1, 9, 32'h90,       1, 9, 32'h99, 1, 32'h200);
        vt[28] = mk(0, 0, 0, 0, 0, 0,                 0, 9, 32'h90, 1, 32'h0);
        vt[29] = mk(0, 0, 0, 1, 0, 32'hAA,            0, 9, 32'h90, 1, 32'h0);
        vt[30] = mk(0, 0, 0, 0, 0, 0,                 0, 0, 32'hAA, 1, 32'h0);

        // Reset held two cycles with a load offered.
        rst = 1'b1;
        drive(0, 0, 0, 1, 5'd1, 32'h1111);
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_ready", {31'b0, mem_ready}, 32'd0);
        chk("rst we", {31'b0, write_enable}, 32'd0);
        chk("rst addr", {27'b0, write_address}, 32'd0);
        chk("rst data", write_data, 32'd0);
        chk("rst mask", pending_mask, 32'd0);
        mem_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("release mem_ready", {31'b0, mem_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].mv, vt[i].mrd, vt[i].md);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d we", i), {31'b0, write_enable}, {31'b0, vt[i].ewe});
            chk($sformatf("v%0d addr", i), {27'b0, write_address}, {27'b0, vt[i].ea});
            chk($sformatf("v%0d data", i), write_data, vt[i].ed);
            chk($sformatf("v%0d ready", i), {31'b0, mem_ready}, {31'b0, vt[i].erdy});
            chk($sformatf("v%0d mask", i), pending_mask, vt[i].emask);
        end

        // Register file contents after the directed sequences.
        chk("rf x1", rf[1], 32'h11);
        chk("rf x2", rf[2], 32'h22);
        chk("rf x4", rf[4], 32'h44);
        chk("rf x5", rf[5], 32'hcafebabe);
        chk("rf x7", rf[7], 32'h73);
        chk("rf x8", rf[8], 32'h82);
        chk("rf x3", rf[3], 32'hdeadbeef);
        chk("rf x6", rf[6], 32'h2);
        chk("rf x9", rf[9], 32'h99);
        chk("rf x0", rf[0], 32'h0);

        // Mid-operation asynchronous reset: three queued loads plus a staged write.
        drive(0, 0, 0, 1, 5'd10, 32'hA0);
        @(posedge clk); #1;
        drive(1, 5'd13, 32'hD0, 1, 5'd11, 32'hB0);
        @(posedge clk); #1;
        drive(1, 5'd13, 32'hD1, 1, 5'd12, 32'hC0);
        @(posedge clk); #1;
        chk("pre-rst we", {31'b0, write_enable}, 32'd1);
        chk("pre-rst mask", pending_mask, 32'h3C00);
        drive(0, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst we", {31'b0, write_enable}, 32'd0);
        chk("async rst addr", {27'b0, write_address}, 32'd0);
        chk("async rst data", write_data, 32'd0);
        chk("async rst mask", pending_mask, 32'd0);
        chk("async rst ready", {31'b0, mem_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post-rst c%0d we", c), {31'b0, write_enable}, 32'd0);
            chk($sformatf("post-rst c%0d mask", c), pending_mask, 32'd0);
        end
        chk("rf x10", rf[10], 32'h0);
        chk("rf x11", rf[11], 32'h0);
        chk("rf x12", rf[12], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
